uart_bus_host: RTL and testbench

Serial debug host that turns command frames received on a UART line into single-word transactions on the system's host-side memory bus. It sits beside the CPU as a second bus initiator, so a PC can peek and poke memory-mapped devices and RAM without software running. It contains its own 8N1 receiver and transmitter, a frame parser, a bus request/response handshake and a reply serializer.

---
 rtl/uart_bus_host.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_bus_host.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_host.sv
// uart_bus_host: UART 8N1 debug host, turns W/R frames into
// single-word bus transactions and serializes the reply.
// Ports:
//   clk_i, rst_i (async, high)  uart_rx_i / uart_tx_o (8N1)
//   host_req_o/gnt_i/addr_o/we_o/be_o/wdata_o   request
//   host_rvalid_i/rdata_i/err_i                 response
//   busy_o  frame FSM outside IDLE
module uart_bus_host #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int TimeoutBauds   = 64,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 busy_o
);
  localparam int Cpb  = ClockFrequency / BaudRate;
  localparam int CntW = $clog2(Cpb + 1);
  localparam int ToW  = $clog2(TimeoutBauds + 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    F_IDLE, F_ADDR, F_DATA,
    F_BUS_REQ, F_BUS_WAIT, F_RESP
  } f_state_t;

  // Free-running baud tick for TX and timeout.
  logic [CntW-1:0] r_baud_cnt;
  logic            w_tick;
  assign w_tick = (r_baud_cnt == CntW'(Cpb - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 1'b1;
  end

  rx_state_t       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CntW-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh;
  logic            r_rx_valid;

  // r_rx_s3 only serves edge detection on the synced line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rx_i;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      unique case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_cnt   <= CntW'(Cpb / 2);
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt   <= CntW'(Cpb - 1);
            r_rx_bit   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_cnt <= CntW'(Cpb - 1);
            r_rx_bit <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7)
              r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            // A low stop bit drops the byte.
            r_rx_valid <= r_rx_s2;
            r_rx_state <= RX_IDLE;
          end
        end
      endcase
    end
  end

  f_state_t             r_state;
  logic [31:0]          r_abuf;
  logic [DataWidth-1:0] r_wdata;
  logic [31:0]          r_reply;
  logic [2:0]           r_rlen;
  logic                 r_we, r_req, r_tx;
  logic [1:0]           r_bcnt;
  logic [ToW-1:0]       r_to;
  logic [3:0]           r_tx_bits;
  logic [8:0]           r_tx_sh;
  logic [31:0]          w_reply;
  logic [2:0]           w_rlen;

  assign w_reply = host_err_i ? 32'h15 :
                   r_we       ? 32'h06 : host_rdata_i;
  assign w_rlen  = (host_err_i || r_we) ? 3'd1 : 3'd4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= F_IDLE;
      r_abuf    <= '0;
      r_wdata   <= '0;
      r_reply   <= '0;
      r_rlen    <= '0;
      r_we      <= 1'b0;
      r_req     <= 1'b0;
      r_tx      <= 1'b1;
      r_bcnt    <= '0;
      r_to      <= '0;
      r_tx_bits <= '0;
      r_tx_sh   <= '1;
    end else begin
      unique case (r_state)
        F_IDLE: begin
          if (r_rx_valid) begin
            r_bcnt <= '0;
            r_to   <= '0;
            if (r_rx_sh == 8'h57) begin
              r_we    <= 1'b1;
              r_state <= F_ADDR;
            end else if (r_rx_sh == 8'h52) begin
              r_we    <= 1'b0;
              r_state <= F_ADDR;
            end else begin
              r_reply <= 32'h15;
              r_rlen  <= 3'd1;
              r_state <= F_RESP;
            end
          end
        end
        F_ADDR, F_DATA: begin
          if (r_rx_valid) begin
            r_to   <= '0;
            r_bcnt <= r_bcnt + 1'b1;
            if (r_state == F_ADDR)
              r_abuf <= {r_rx_sh, r_abuf[31:8]};
            else
              r_wdata <= {r_rx_sh, r_wdata[DataWidth-1:8]};
            if (r_bcnt == 2'd3) begin
              if (r_state == F_ADDR && r_we) begin
                r_state <= F_DATA;
              end else begin
                r_req   <= 1'b1;
                r_state <= F_BUS_REQ;
              end
            end
          end else if (w_tick) begin
            if (r_to == ToW'(TimeoutBauds - 1))
              r_state <= F_IDLE;
            else
              r_to <= r_to + 1'b1;
          end
        end
        F_BUS_REQ: begin
          if (host_gnt_i) begin
            r_req <= 1'b0;
            if (host_rvalid_i) begin
              r_reply <= w_reply;
              r_rlen  <= w_rlen;
              r_state <= F_RESP;
            end else begin
              r_state <= F_BUS_WAIT;
            end
          end
        end
        F_BUS_WAIT: begin
          if (host_rvalid_i) begin
            r_reply <= w_reply;
            r_rlen  <= w_rlen;
            r_state <= F_RESP;
          end
        end
        F_RESP: begin
          // r_tx_bits == 0: stop bit done or idle.
          if (w_tick) begin
            if (r_tx_bits != '0) begin
              r_tx      <= r_tx_sh[0];
              r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
              r_tx_bits <= r_tx_bits - 1'b1;
            end else if (r_rlen != '0) begin
              r_tx      <= 1'b0;
              r_tx_sh   <= {1'b1, r_reply[7:0]};
              r_reply   <= {8'h00, r_reply[31:8]};
              r_rlen    <= r_rlen - 1'b1;
              r_tx_bits <= 4'd9;
            end else begin
              r_state <= F_IDLE;
            end
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  assign uart_tx_o    = r_tx;
  assign host_req_o   = r_req;
  assign host_we_o    = r_we;
  assign host_be_o    = 4'hF;
  assign host_addr_o  = {r_abuf[AddrWidth-1:2], 2'b00};
  assign host_wdata_o = r_wdata;
  assign busy_o       = (r_state != F_IDLE);

endmodule

// File: tb/tb_uart_bus_host.sv
// tb_uart_bus_host: directed bench for uart_bus_host with a
// UART byte monitor and a simple bus responder.
module tb_uart_bus_host;
  localparam int CPB = 10;

  logic        clk_i, rst_i, uart_rx_i, uart_tx_o;
  logic        host_req_o, host_gnt_i, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;
  logic        host_rvalid_i, host_err_i, busy_o;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int stall_bad = 0;
  int gnt_stall = 0;
  int rv_delay = 1;
  int base;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_err = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [7:0]  rx_q[$];

  uart_bus_host #(
    .ClockFrequency(1_000_000),
    .BaudRate(100_000),
    .TimeoutBauds(64),
    .AddrWidth(32),
    .DataWidth(32)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .uart_rx_i(uart_rx_i),
    .uart_tx_o(uart_tx_o),
    .host_req_o(host_req_o),
    .host_gnt_i(host_gnt_i),
    .host_addr_o(host_addr_o),
    .host_we_o(host_we_o),
    .host_be_o(host_be_o),
    .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i),
    .host_rdata_i(host_rdata_i),
    .host_err_i(host_err_i),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reply monitor: decodes 8N1 bytes from uart_tx_o.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      if (uart_tx_o === 1'b0) begin
        repeat (CPB / 2) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_i);
          b[i] = uart_tx_o;
        end
        repeat (CPB) @(negedge clk_i);
        rx_q.push_back(b);
      end
    end
  end

  // Bus responder with programmable grant stall and latency.
  initial begin
    host_gnt_i    = 1'b0;
    host_rvalid_i = 1'b0;
    host_rdata_i  = '0;
    host_err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      if (host_req_o === 1'b1) begin
        req_cnt++;
        cap_addr  = host_addr_o;
        cap_we    = host_we_o;
        cap_wdata = host_wdata_o;
        cap_be    = host_be_o;
        for (int i = 0; i < gnt_stall; i++) begin
          if (host_req_o !== 1'b1 ||
              host_addr_o !== cap_addr ||
              host_we_o !== cap_we ||
              host_wdata_o !== cap_wdata)
            stall_bad++;
          @(negedge clk_i);
        end
        host_gnt_i = 1'b1;
        @(negedge clk_i);
        host_gnt_i = 1'b0;
        if (host_req_o !== 1'b0) stall_bad++;
        repeat (rv_delay - 1) @(negedge clk_i);
        host_rvalid_i = 1'b1;
        host_rdata_i  = bus_rdata;
        host_err_i    = bus_err;
        @(negedge clk_i);
        host_rvalid_i = 1'b0;
        host_rdata_i  = '0;
        host_err_i    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop_v);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop_v;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
  endtask

  // Bytes are listed first-sent at the most significant end.
  task automatic send_vec(input logic [71:0] v, input int n);
    for (int k = 0; k < n; k++)
      send_byte(v[8*(n-1-k) +: 8], 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (busy_o === 1'b0) break;
      @(negedge clk_i);
    end
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_q(input string tag, input int n);
    for (int i = 0; i < 3000; i++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk_i);
    end
    chk(tag, {31'd0, rx_q.size() >= n}, 32'd1);
  endtask

  function automatic logic [7:0] qb(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'h00;
  endfunction

  initial begin
    rst_i     = 1'b1;
    uart_rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("rst_req", {31'd0, host_req_o}, 32'd0);
    chk("rst_we", {31'd0, host_we_o}, 32'd0);
    chk("rst_addr", host_addr_o, 32'd0);
    chk("rst_wdata", host_wdata_o, 32'd0);
    chk("rst_be", {28'd0, host_be_o}, 32'hF);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    repeat (3 * CPB) @(negedge clk_i);

    // Write
    base = req_cnt;
    rx_q.delete();
    send_byte(8'h57, 1'b1);
    chk("wr_busy", {31'd0, busy_o}, 32'd1);
    send_vec(72'h10_00_00_80_EF_BE_AD_DE, 8);
    wait_done("wr_done");
    chk("wr_nreq", req_cnt - base, 32'd1);
    chk("wr_addr", cap_addr, 32'h8000_0010);
    chk("wr_we", {31'd0, cap_we}, 32'd1);
    chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("wr_be", {28'd0, cap_be}, 32'hF);
    chk("wr_nrx", rx_q.size(), 32'd1);
    chk("wr_ack", {24'd0, qb(0)}, 32'h06);

    // Read with 3-cycle latency
    base = req_cnt;
    rx_q.delete();
    bus_rdata = 32'h1234_5678;
    rv_delay  = 3;
    send_vec(72'h52_04_00_00_80, 5);
    wait_done("rd_done");
    chk("rd_nreq", req_cnt - base, 32'd1);
    chk("rd_addr", cap_addr, 32'h8000_0004);
    chk("rd_we", {31'd0, cap_we}, 32'd0);
    chk("rd_nrx", rx_q.size(), 32'd4);
    chk("rd_data",
        {qb(3), qb(2), qb(1), qb(0)}, 32'h1234_5678);
    rv_delay = 1;

    // Bus error
    rx_q.delete();
    bus_err = 1'b1;
    send_vec(72'h52_08_00_00_00, 5);
    wait_done("err_done");
    chk("err_nrx", rx_q.size(), 32'd1);
    chk("err_nak", {24'd0, qb(0)}, 32'h15);
    bus_err = 1'b0;

    // Unknown command
    base = req_cnt;
    rx_q.delete();
    send_byte(8'h41, 1'b1);
    wait_done("unk_done");
    chk("unk_nreq", req_cnt - base, 32'd0);
    chk("unk_nrx", rx_q.size(), 32'd1);
    chk("unk_nak", {24'd0, qb(0)}, 32'h15);

    // Grant stall of 20 cycles
    rx_q.delete();
    gnt_stall = 20;
    stall_bad = 0;
    bus_rdata = 32'hAABB_CCDD;
    send_vec(72'h52_01_01_00_00, 5);
    wait_done("stl_done");
    chk("stl_stable", stall_bad, 32'd0);
    chk("stl_addr", cap_addr, 32'h0000_0100);
    chk("stl_data",
        {qb(3), qb(2), qb(1), qb(0)}, 32'hAABB_CCDD);
    gnt_stall = 0;

    // Timeout of a partial frame
    base = req_cnt;
    rx_q.delete();
    send_vec(72'h57_01, 2);
    repeat (60 * CPB) @(negedge clk_i);
    chk("to_pending", {31'd0, busy_o}, 32'd1);
    repeat (6 * CPB) @(negedge clk_i);
    chk("to_idle", {31'd0, busy_o}, 32'd0);
    chk("to_norx", rx_q.size(), 32'd0);
    bus_rdata = 32'h0BAD_F00D;
    send_vec(72'h52_20_00_00_00, 5);
    wait_done("to_rd_done");
    chk("to_nreq", req_cnt - base, 32'd1);
    chk("to_we", {31'd0, cap_we}, 32'd0);
    chk("to_addr", cap_addr, 32'h0000_0020);
    chk("to_data",
        {qb(3), qb(2), qb(1), qb(0)}, 32'h0BAD_F00D);

    // Framing error byte is dropped
    base = req_cnt;
    rx_q.delete();
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk_i);
    chk("fe_busy", {31'd0, busy_o}, 32'd0);
    bus_rdata = 32'h0000_00C3;
    send_vec(72'h52_30_00_00_00, 5);
    wait_done("fe_rd_done");
    chk("fe_nreq", req_cnt - base, 32'd1);
    chk("fe_we", {31'd0, cap_we}, 32'd0);
    chk("fe_addr", cap_addr, 32'h0000_0030);
    chk("fe_nrx", rx_q.size(), 32'd4);

    // Reset during reply byte 2 (0x00, line low)
    rx_q.delete();
    bus_rdata = 32'h5566_0099;
    send_vec(72'h52_50_00_00_00, 5);
    wait_q("rs_b1", 1);
    repeat (3 * CPB) @(negedge clk_i);
    chk("rs_pre_tx", {31'd0, uart_tx_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rs_tx", {31'd0, uart_tx_o}, 32'd1);
    chk("rs_req", {31'd0, host_req_o}, 32'd0);
    chk("rs_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12 * CPB) @(negedge clk_i);
    rx_q.delete();
    chk("rs_tx_idle", {31'd0, uart_tx_o}, 32'd1);
    base = req_cnt;
    send_vec(72'h57_40_00_00_00_78_56_34_12, 9);
    wait_done("rs_wr_done");
    chk("rs_nreq", req_cnt - base, 32'd1);
    chk("rs_addr", cap_addr, 32'h0000_0040);
    chk("rs_wdata", cap_wdata, 32'h1234_5678);
    chk("rs_nrx", rx_q.size(), 32'd1);
    chk("rs_ack", {24'd0, qb(0)}, 32'h06);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
